// File: rtl/btb_update_queue_if.sv
// btb_update_queue_if: resolution intake from the branch units and update port towards the BTB.
interface btb_update_queue_if #(
   parameter int VLEN = 64
);
   logic [1:0]        res_valid;
   logic [1:0]        res_mispredict;
   logic [2*VLEN-1:0] res_pc;
   logic [2*VLEN-1:0] res_target;
   logic              res_ready;
   logic              update_hold;
   logic              btb_update_valid;
   logic [VLEN-1:0]   btb_update_pc;
   logic [VLEN-1:0]   btb_update_target;
   modport master(
      output res_valid, res_mispredict, res_pc, res_target, update_hold,
      input  res_ready, btb_update_valid, btb_update_pc, btb_update_target
   );
   modport slave(
      input  res_valid, res_mispredict, res_pc, res_target, update_hold,
      output res_ready, btb_update_valid, btb_update_pc, btb_update_target
   );
endinterface

// File: rtl/btb_update_queue.sv
// btb_update_queue: buffers mispredicted branch resolutions (two per cycle, merged by PC)
// and drains them one per cycle as BTB update writes.
module btb_update_queue #(
   parameter int VLEN  = 64,
   parameter int DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_bp_i,
   input  logic                         debug_mode_i,
   btb_update_queue_if.slave            bus,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   head_q, head_d, tail_q, tail_d, last_idx;
   logic [VLEN-1:0] pc_q [DEPTH];
   logic [VLEN-1:0] pc_d [DEPTH];
   logic [VLEN-1:0] tgt_q [DEPTH];
   logic [VLEN-1:0] tgt_d [DEPTH];
   logic [1:0]      cand, n_enq;
   logic            pop, has_last, ready;
   logic [VLEN-1:0] lpc, ltgt;
   assign ready                 = count_q <= CW'(DEPTH-2);
   assign pop                   = rst_ni && count_q != '0 && !bus.update_hold && !flush_bp_i;
   assign bus.res_ready         = ready;
   assign bus.btb_update_valid  = pop;
   assign bus.btb_update_pc     = count_q != '0 ? pc_q[head_q] : '0;
   assign bus.btb_update_target = count_q != '0 ? tgt_q[head_q] : '0;
   assign occupancy_o           = count_q;
   always_comb begin
      cand = bus.res_valid & bus.res_mispredict & {2{ready && !debug_mode_i && !flush_bp_i}};
      cand[0] = cand[0] && !(cand[1] && bus.res_pc[VLEN-1:0] == bus.res_pc[2*VLEN-1:VLEN]);
      pc_d = pc_q;
      tgt_d = tgt_q;
      tail_d = tail_q;
      n_enq = '0;
      lpc = '0;
      ltgt = '0;
      // the newest entry may absorb a same-PC update unless it leaves the queue this cycle
      has_last = count_q != '0 && !(pop && count_q == CW'(1));
      last_idx = tail_q - PW'(1);
      for (int l = 0; l < 2; l++) begin
         lpc = bus.res_pc[l*VLEN +: VLEN];
         ltgt = bus.res_target[l*VLEN +: VLEN];
         if (cand[l] && has_last && pc_d[last_idx] == lpc) begin
            tgt_d[last_idx] = ltgt;
         end else if (cand[l]) begin
            pc_d[tail_d] = lpc;
            tgt_d[tail_d] = ltgt;
            last_idx = tail_d;
            tail_d = tail_d + PW'(1);
            has_last = 1'b1;
            n_enq = n_enq + 2'd1;
         end
      end
      count_d = flush_bp_i ? '0 : count_q + CW'(n_enq) - CW'(pop);
      head_d = flush_bp_i ? '0 : head_q + PW'(pop);
      tail_d = flush_bp_i ? '0 : tail_d;
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         count_q <= count_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end
   always_ff @(posedge clk_i) begin
      pc_q <= pc_d;
      tgt_q <= tgt_d;
   end
endmodule

// File: tb/tb_btb_update_queue.sv
// tb_btb_update_queue: directed and randomized checks of btb_update_queue against a
// queue-based reference model.
module tb_btb_update_queue;
   localparam int VLEN = 64;
   localparam int DEPTH = 4;
   typedef struct { logic [63:0] pc; logic [63:0] tgt; } ent_t;
   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic flush_bp_i = 1'b0;
   logic debug_mode_i = 1'b0;
   logic [2:0] occupancy_o;
   logic [132:0] dut_vec;
   ent_t q[$];
   int tests = 0;
   int fails = 0;
   btb_update_queue_if #(.VLEN(VLEN)) bus();
   btb_update_queue #(.VLEN(VLEN), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_bp_i(flush_bp_i),
      .debug_mode_i(debug_mode_i), .bus(bus), .occupancy_o(occupancy_o)
   );
   always #5 clk_i = ~clk_i;
   assign dut_vec = {bus.btb_update_valid, bus.btb_update_pc, bus.btb_update_target, bus.res_ready, occupancy_o};
   function automatic logic [132:0] exp_vec();
      int n = q.size();
      logic v = rst_ni && n != 0 && !bus.update_hold && !flush_bp_i;
      return {v, n != 0 ? q[0].pc : 64'd0, n != 0 ? q[0].tgt : 64'd0, 1'(n <= DEPTH-2), 3'(n)};
   endfunction
   task automatic drive(input logic [1:0] v, input logic [1:0] m, input logic [63:0] p0, input logic [63:0] t0,
                        input logic [63:0] p1, input logic [63:0] t1);
      bus.res_valid = v;
      bus.res_mispredict = m;
      bus.res_pc = {p1, p0};
      bus.res_target = {t1, t0};
   endtask
   task automatic idle();
      drive(2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0);
   endtask
   // reference model: pop the head, then apply each surviving lane as merge-into-newest or append
   task automatic step();
      int n = q.size();
      bit rdy = n <= DEPTH-2;
      bit vld = rst_ni && n != 0 && !bus.update_hold && !flush_bp_i;
      if (!rst_ni || flush_bp_i) q.delete();
      else begin
         if (vld) void'(q.pop_front());
         for (int l = 0; l < 2; l++) begin
            if (bus.res_valid[l] && bus.res_mispredict[l] && rdy && !debug_mode_i) begin
               ent_t e;
               e.pc = bus.res_pc[l*64 +: 64];
               e.tgt = bus.res_target[l*64 +: 64];
               if (q.size() != 0 && q[q.size()-1].pc == e.pc) q[q.size()-1] = e;
               else q.push_back(e);
            end
         end
      end
      @(posedge clk_i);
      #1;
   endtask
   task automatic test_reset();
      rst_ni = 1'b0;
      bus.update_hold = 1'b0;
      idle();
      step();
      step();
      rst_ni = 1'b1;
      #1;
      tests++; if (bus.btb_update_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.btb_update_valid); end
      tests++; if (occupancy_o !== 3'd0) begin fails++; $display("FAIL reset_occ: got %0d want 0", occupancy_o); end
      tests++; if (bus.res_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", bus.res_ready); end
      tests++; if (bus.btb_update_pc !== 64'd0) begin fails++; $display("FAIL reset_pc: got %h want 0", bus.btb_update_pc); end
   endtask
   task automatic test_single();
      drive(2'b01, 2'b01, 64'h1000, 64'h2000, 64'd0, 64'd0);
      #1;
      tests++; if (bus.btb_update_valid !== 1'b0) begin fails++; $display("FAIL single_no_bypass: got %b want 0", bus.btb_update_valid); end
      step();
      idle();
      #1;
      tests++; if ({bus.btb_update_valid, bus.btb_update_pc, bus.btb_update_target} !== {1'b1, 64'h1000, 64'h2000})
         begin fails++; $display("FAIL single_out: got %b %h %h want 1 1000 2000", bus.btb_update_valid, bus.btb_update_pc, bus.btb_update_target); end
      step();
      tests++; if (occupancy_o !== 3'd0) begin fails++; $display("FAIL single_drained: got %0d want 0", occupancy_o); end
   endtask
   task automatic test_intra_merge();
      drive(2'b11, 2'b11, 64'h40, 64'h80, 64'h40, 64'hC0);
      step();
      idle();
      #1;
      tests++; if ({occupancy_o, bus.btb_update_pc, bus.btb_update_target} !== {3'd1, 64'h40, 64'hC0})
         begin fails++; $display("FAIL intra_merge: got %0d %h %h want 1 40 c0", occupancy_o, bus.btb_update_pc, bus.btb_update_target); end
      step();
      drive(2'b11, 2'b01, 64'h50, 64'h1, 64'h60, 64'h2);
      step();
      idle();
      #1;
      tests++; if ({occupancy_o, bus.btb_update_pc} !== {3'd1, 64'h50})
         begin fails++; $display("FAIL lane1_correct: got %0d %h want 1 50", occupancy_o, bus.btb_update_pc); end
      step();
   endtask
   task automatic test_full_drain();
      bus.update_hold = 1'b1;
      drive(2'b11, 2'b11, 64'hA00, 64'hB00, 64'hA08, 64'hB08);
      step();
      drive(2'b11, 2'b11, 64'hA10, 64'hB10, 64'hA18, 64'hB18);
      step();
      idle();
      #1;
      tests++; if ({occupancy_o, bus.res_ready, bus.btb_update_valid} !== {3'd4, 1'b0, 1'b0})
         begin fails++; $display("FAIL full: got occ %0d rdy %b vld %b want 4 0 0", occupancy_o, bus.res_ready, bus.btb_update_valid); end
      bus.update_hold = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         tests++; if ({bus.btb_update_valid, bus.btb_update_pc, bus.btb_update_target, bus.res_ready} !==
                      {1'b1, 64'hA00 + 64'(8*i), 64'hB00 + 64'(8*i), 1'(i >= 2)})
            begin fails++; $display("FAIL drain_%0d: got %b %h %h rdy %b", i, bus.btb_update_valid, bus.btb_update_pc, bus.btb_update_target, bus.res_ready); end
         step();
      end
      tests++; if (occupancy_o !== 3'd0) begin fails++; $display("FAIL drain_empty: got %0d want 0", occupancy_o); end
   endtask
   task automatic test_tail_merge();
      bus.update_hold = 1'b1;
      drive(2'b01, 2'b01, 64'h100, 64'h200, 64'd0, 64'd0);
      step();
      drive(2'b01, 2'b01, 64'h100, 64'h300, 64'd0, 64'd0);
      step();
      idle();
      #1;
      tests++; if (occupancy_o !== 3'd1) begin fails++; $display("FAIL tail_merge_occ: got %0d want 1", occupancy_o); end
      bus.update_hold = 1'b0;
      #1;
      tests++; if ({bus.btb_update_valid, bus.btb_update_pc, bus.btb_update_target} !== {1'b1, 64'h100, 64'h300})
         begin fails++; $display("FAIL tail_merge_out: got %b %h %h want 1 100 300", bus.btb_update_valid, bus.btb_update_pc, bus.btb_update_target); end
      step();
   endtask
   task automatic test_flush();
      bus.update_hold = 1'b1;
      drive(2'b11, 2'b11, 64'h300, 64'h1, 64'h308, 64'h2);
      step();
      drive(2'b01, 2'b01, 64'h310, 64'h3, 64'd0, 64'd0);
      step();
      tests++; if (occupancy_o !== 3'd3) begin fails++; $display("FAIL flush_fill: got %0d want 3", occupancy_o); end
      bus.update_hold = 1'b0;
      flush_bp_i = 1'b1;
      drive(2'b11, 2'b11, 64'h400, 64'h4, 64'h408, 64'h5);
      #1;
      tests++; if (bus.btb_update_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b want 0", bus.btb_update_valid); end
      step();
      flush_bp_i = 1'b0;
      idle();
      #1;
      tests++; if ({occupancy_o, bus.btb_update_valid} !== {3'd0, 1'b0})
         begin fails++; $display("FAIL flush_empty: got occ %0d vld %b want 0 0", occupancy_o, bus.btb_update_valid); end
   endtask
   task automatic test_debug();
      bus.update_hold = 1'b1;
      drive(2'b11, 2'b11, 64'h500, 64'h6, 64'h508, 64'h7);
      step();
      bus.update_hold = 1'b0;
      debug_mode_i = 1'b1;
      drive(2'b11, 2'b11, 64'h600, 64'h8, 64'h608, 64'h9);
      #1;
      for (int i = 0; i < 2; i++) begin
         tests++; if ({bus.btb_update_valid, bus.btb_update_pc} !== {1'b1, 64'h500 + 64'(8*i)})
            begin fails++; $display("FAIL debug_drain_%0d: got %b %h", i, bus.btb_update_valid, bus.btb_update_pc); end
         step();
      end
      tests++; if (occupancy_o !== 3'd0) begin fails++; $display("FAIL debug_drop: got %0d want 0", occupancy_o); end
      debug_mode_i = 1'b0;
      idle();
   endtask
   task automatic test_reset_mid();
      bus.update_hold = 1'b1;
      drive(2'b11, 2'b11, 64'h700, 64'h1, 64'h708, 64'h2);
      step();
      drive(2'b01, 2'b01, 64'h710, 64'h3, 64'd0, 64'd0);
      step();
      idle();
      bus.update_hold = 1'b0;
      rst_ni = 1'b0;
      #1;
      tests++; if (bus.btb_update_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_cycle: got %b want 0", bus.btb_update_valid); end
      step();
      rst_ni = 1'b1;
      #1;
      tests++; if ({bus.btb_update_valid, occupancy_o, bus.res_ready} !== {1'b0, 3'd0, 1'b1})
         begin fails++; $display("FAIL rst_mid_after: got vld %b occ %0d rdy %b want 0 0 1", bus.btb_update_valid, occupancy_o, bus.res_ready); end
   endtask
   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         bus.update_hold = $urandom_range(0, 3) == 0;
         flush_bp_i = $urandom_range(0, 19) == 0;
         debug_mode_i = $urandom_range(0, 9) == 0;
         drive(2'($urandom), 2'($urandom_range(0, 3) | ($urandom_range(0, 1) ? 2'b11 : 2'b00)),
               64'($urandom_range(1, 4)) << 4, 64'($urandom), 64'($urandom_range(1, 4)) << 4, 64'($urandom));
         #1;
         tests++; if (dut_vec !== exp_vec()) begin fails++; $display("FAIL random_%0d: got %h want %h", c, dut_vec, exp_vec()); end
         step();
      end
      bus.update_hold = 1'b0;
      flush_bp_i = 1'b0;
      debug_mode_i = 1'b0;
      idle();
      for (int c = 0; c < 5; c++) step();
      tests++; if (dut_vec !== exp_vec()) begin fails++; $display("FAIL random_tail: got %h want %h", dut_vec, exp_vec()); end
   endtask
   initial begin
      test_reset();
      test_single();
      test_intra_merge();
      test_full_drain();
      test_tail_merge();
      test_flush();
      test_debug();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
